// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: free-running H/V counters with registered sync,
// blank and start qualifiers, all aligned to the DrawX/DrawY they describe.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode thresholds are one bit wider so a 1024-wide timing still compares correctly.
  localparam logic [10:0] H_ACT  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  hc, vc;
  logic [9:0]  hc_nxt, vc_nxt;
  logic [10:0] hx, vy;
  logic        at_origin;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    hc_nxt = hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
    end
  end

  assign hx        = {1'b0, hc_nxt};
  assign vy        = {1'b0, vc_nxt};
  assign at_origin = (hc_nxt == '0) && (vc_nxt == '0);

  // Qualifiers are decoded from the next counter values so they land in the
  // same cycle as the coordinates they describe.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (pix_en) begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hs          <= (hx >= HS_ON && hx < HS_OFF) ? SYNC_POL : ~SYNC_POL;
      vs          <= (vy >= VS_ON && vy < VS_OFF) ? SYNC_POL : ~SYNC_POL;
      blank       <= (hx < H_ACT) && (vy < V_ACT);
      line_start  <= (hc_nxt == '0);
      frame_start <= at_origin;
      if (at_origin) frame_count <= frame_count + 8'd1;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: the driver pushes the expected per-cycle state of three
// differently-parameterised instances; a negedge monitor pops and compares.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int hv, hf, hsy, hb, vv, vf, vsy, vb;
  } tim_t;

  tim_t t_d = '{640, 16, 96, 48, 480, 10, 2, 33};
  tim_t t_h = '{320, 8, 48, 24, 480, 10, 2, 33};
  tim_t t_t = '{8, 2, 3, 3, 4, 1, 2, 1};

  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  logic pix_en  = 1'b0;

  logic [9:0] x_d, y_d, x_h, y_h, x_t, y_t;
  logic       hs_d, vs_d, bl_d, ls_d, fs_d;
  logic       hs_h, vs_h, bl_h, ls_h, fs_h;
  logic       hs_t, vs_t, bl_t, ls_t, fs_t;
  logic [7:0] fc_d, fc_h, fc_t;

  int   checks = 0;
  int   errors = 0;
  int   n      = 0;
  obs_t q_d[$], q_h[$], q_t[$];

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(x_d), .DrawY(y_d), .hs(hs_d), .vs(vs_d), .blank(bl_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(.H_VISIBLE(320), .H_FP(8), .H_SYNC(48), .H_BP(24)) dut_h (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(x_h), .DrawY(y_h), .hs(hs_h), .vs(vs_h), .blank(bl_h),
    .line_start(ls_h), .frame_start(fs_h), .frame_count(fc_h)
  );

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_t (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(x_t), .DrawY(y_t), .hs(hs_t), .vs(vs_t), .blank(bl_t),
    .line_start(ls_t), .frame_start(fs_t), .frame_count(fc_t)
  );

  // Expected state after k enabled edges, written in closed form from the edge count.
  function automatic obs_t model(input int k, input tim_t t);
    obs_t r;
    int ht, vt, p, x, y, f;
    ht = t.hv + t.hf + t.hsy + t.hb;
    vt = t.vv + t.vf + t.vsy + t.vb;
    if (k == 0) begin
      r = '{x: 10'(ht - 1), y: 10'(vt - 1), hs: 1'b1, vs: 1'b1,
            blank: 1'b0, ls: 1'b0, fs: 1'b0, fc: 8'd0};
      return r;
    end
    p = k - 1;
    x = p % ht;
    y = (p / ht) % vt;
    f = p / (ht * vt) + 1;
    r.x     = 10'(x);
    r.y     = 10'(y);
    r.hs    = !(x >= t.hv + t.hf && x < t.hv + t.hf + t.hsy);
    r.vs    = !(y >= t.vv + t.vf && y < t.vv + t.vf + t.vsy);
    r.blank = (x < t.hv) && (y < t.vv);
    r.ls    = (x == 0);
    r.fs    = (x == 0) && (y == 0);
    r.fc    = 8'(f % 256);
    return r;
  endfunction

  task automatic cmp(input string name, input obs_t e, input obs_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d",
               name, $time, a.x, a.y, a.hs, a.vs, a.blank, a.ls, a.fs, a.fc,
               e.x, e.y, e.hs, e.vs, e.blank, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  always @(negedge vga_clk) begin
    if (q_d.size() > 0)
      cmp("dut_default", q_d.pop_front(), {x_d, y_d, hs_d, vs_d, bl_d, ls_d, fs_d, fc_d});
    if (q_h.size() > 0)
      cmp("dut_h320", q_h.pop_front(), {x_h, y_h, hs_h, vs_h, bl_h, ls_h, fs_h, fc_h});
    if (q_t.size() > 0)
      cmp("dut_tiny", q_t.pop_front(), {x_t, y_t, hs_t, vs_t, bl_t, ls_t, fs_t, fc_t});
  end

  // One clock: drive pix_en clear of the edge, then queue what each instance must show.
  task automatic step(input logic en);
    #1 pix_en = en;
    @(posedge vga_clk);
    if (en && reset_n) n++;
    q_d.push_back(model(n, t_d));
    q_h.push_back(model(n, t_h));
    q_t.push_back(model(n, t_t));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) step(1'b1);
    #2 reset_n = 1'b1;

    // Two-plus default lines, covering blank edge, hsync window and line wrap.
    repeat (1700) step(1'b1);

    // Half-rate enable: state and pulses hold across disabled cycles.
    for (int i = 0; i < 300; i++) step(i[0] == 1'b0);

    // Run the tiny timing through more than 256 frames so frame_count wraps.
    while (n < 32768 + 300) step(1'b1);

    // Park the default instance at DrawX=700 (inside hsync) and reset mid-line.
    while (((n - 1) % 800) != 700) step(1'b1);
    #3;
    check_val("pre_reset_x", int'(x_d), 700);
    check_val("pre_reset_hs", int'(hs_d), 0);
    #4 reset_n = 1'b0;
    #1;
    check_val("async_reset_hs", int'(hs_d), 1);
    check_val("async_reset_x", int'(x_d), 799);
    check_val("async_reset_y", int'(y_d), 524);
    check_val("async_reset_blank", int'(bl_d), 0);
    check_val("async_reset_fc", int'(fc_d), 0);
    check_val("async_reset_tiny_fc", int'(fc_t), 0);
    n = 0;
    repeat (2) step(1'b1);
    #2 reset_n = 1'b1;
    repeat (20) step(1'b1);

    @(negedge vga_clk);
    #1;
    check_val("queues_drained", q_d.size() + q_h.size() + q_t.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
